mem_wb_stage: RTL and testbench

- Memory/write-back stage that consumes the buffered EX-side control and data: register-bank write enable, RAM write/read strobes, ALU result, and the DR2 store data.
- Performs the data-RAM access against an internal word-addressed RAM with configurable read latency.
- Presents registered write-back data, destination and write enable to the register bank.
- Raises a stall toward the pipeline buffer while a multi-cycle load is outstanding.

---
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory / write-back pipeline stage.
// Takes the buffered EX-side control and data, performs the data-RAM access
// against an internal word-addressed RAM, and presents registered
// write-back data, destination and write enable to the register bank.
// A multi-cycle load raises stall until its result is delivered.
// Optional build macro: MEM_ALIGN_CHECK_EN adds a registered misalign flag
// and suppresses/zeroes misaligned stores/loads.
module mem_wb_stage #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        dataIn_wE_BR,
  input  logic        dataIn_W_ram,
  input  logic        dataIn_R_ram,
  input  logic [31:0] dataIn_DW_alu,
  input  logic [31:0] dataIn_DR2,
  input  logic [4:0]  dataIn_WA,
  output logic        stall,
  output logic        dataOut_wE_BR,
  output logic [31:0] dataOut_DW,
  output logic [4:0]  dataOut_WA,
  output logic        out_valid
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Counter preload; only meaningful when READ_LAT > 1.
  localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_t            state;
  logic [1:0]        cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] capIdx;
  logic [4:0]        capWA;
  logic              capWE;
  logic              capMis;
  logic              addrMis;
  logic              storeAcc;

  // Word index: byte address >> 2, truncated so high addresses wrap.
  assign idx = dataIn_DW_alu[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign addrMis = |dataIn_DW_alu[1:0];
`else
  assign addrMis = 1'b0;
`endif

  // A store wins over a simultaneous load strobe; misaligned stores never write.
  assign storeAcc = (state == IDLE) && in_valid && dataIn_W_ram && !addrMis && !rst;

  // Data RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (storeAcc) begin
      mem[idx] <= dataIn_DR2;
    end
  end

  // Stage control: accept in IDLE, count down load latency in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      stall         <= 1'b0;
      capIdx        <= '0;
      capWA         <= '0;
      capWE         <= 1'b0;
      capMis        <= 1'b0;
      out_valid     <= 1'b0;
      dataOut_wE_BR <= 1'b0;
      dataOut_DW    <= '0;
      dataOut_WA    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
    end else begin
      // Non-completing cycles: no write-back, data/destination hold.
      out_valid     <= 1'b0;
      dataOut_wE_BR <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dataIn_W_ram) begin
              out_valid     <= 1'b1;
              dataOut_DW    <= dataIn_DW_alu;
              dataOut_WA    <= dataIn_WA;
              dataOut_wE_BR <= dataIn_wE_BR;
`ifdef MEM_ALIGN_CHECK_EN
              misalign      <= addrMis;
`endif
            end else if (dataIn_R_ram) begin
              if (READ_LAT == 1) begin
                out_valid     <= 1'b1;
                dataOut_DW    <= addrMis ? '0 : mem[idx];
                dataOut_WA    <= dataIn_WA;
                dataOut_wE_BR <= dataIn_wE_BR && !addrMis;
`ifdef MEM_ALIGN_CHECK_EN
                misalign      <= addrMis;
`endif
              end else begin
                capIdx <= idx;
                capWA  <= dataIn_WA;
                capWE  <= dataIn_wE_BR;
                capMis <= addrMis;
                cnt    <= CNT_INIT;
                stall  <= 1'b1;
                state  <= WAIT;
              end
            end else begin
              out_valid     <= 1'b1;
              dataOut_DW    <= dataIn_DW_alu;
              dataOut_WA    <= dataIn_WA;
              dataOut_wE_BR <= dataIn_wE_BR;
            end
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            out_valid     <= 1'b1;
            dataOut_DW    <= capMis ? '0 : mem[capIdx];
            dataOut_WA    <= capWA;
            dataOut_wE_BR <= capWE && !capMis;
`ifdef MEM_ALIGN_CHECK_EN
            misalign      <= capMis;
`endif
            stall         <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          stall <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
// dut uses READ_LAT=2, dut4 uses READ_LAT=4; both share stimulus.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        wE = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] dr2 = '0;
  logic [4:0]  wa = '0;

  logic        d_stall, d_wE, d_ov;
  logic [31:0] d_DW;
  logic [4:0]  d_WA;
  logic        q_stall, q_wE, q_ov;
  logic [31:0] q_DW;
  logic [4:0]  q_WA;
`ifdef MEM_ALIGN_CHECK_EN
  logic        d_mis, q_mis;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(64), .ADDR_W(6), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .dataIn_wE_BR(wE), .dataIn_W_ram(wr), .dataIn_R_ram(rd),
    .dataIn_DW_alu(alu), .dataIn_DR2(dr2), .dataIn_WA(wa),
    .stall(d_stall), .dataOut_wE_BR(d_wE), .dataOut_DW(d_DW),
    .dataOut_WA(d_WA), .out_valid(d_ov)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign(d_mis)
`endif
  );

  mem_wb_stage #(.DEPTH(64), .ADDR_W(6), .READ_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .dataIn_wE_BR(wE), .dataIn_W_ram(wr), .dataIn_R_ram(rd),
    .dataIn_DW_alu(alu), .dataIn_DR2(dr2), .dataIn_WA(wa),
    .stall(q_stall), .dataOut_wE_BR(q_wE), .dataOut_DW(q_DW),
    .dataOut_WA(q_WA), .out_valid(q_ov)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign(q_mis)
`endif
  );

  task automatic drive(input logic v, input logic we, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra);
    in_valid = v; wE = we; wr = w; rd = r; alu = a; dr2 = d; wa = ra;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (n) tick();
  endtask

  task automatic test_reset;
    #2;
    checks++; if (d_ov !== 1'b0) begin fails++; $display("FAIL rst_ov: got %b want 0", d_ov); end
    checks++; if (d_wE !== 1'b0) begin fails++; $display("FAIL rst_wE: got %b want 0", d_wE); end
    checks++; if (d_DW !== 32'h0) begin fails++; $display("FAIL rst_DW: got %h want 0", d_DW); end
    checks++; if (d_WA !== 5'h0) begin fails++; $display("FAIL rst_WA: got %h want 0", d_WA); end
    checks++; if (d_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", d_stall); end
    checks++; if (q_stall !== 1'b0) begin fails++; $display("FAIL rst_stall4: got %b want 0", q_stall); end
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (d_mis !== 1'b0) begin fails++; $display("FAIL rst_mis: got %b want 0", d_mis); end
`endif
    #10 rst = 1'b0;
  endtask

  task automatic test_alu;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0, 5'd3);
    tick();
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL alu_ov: got %b want 1", d_ov); end
    checks++; if (d_DW !== 32'h0000_00A5) begin fails++; $display("FAIL alu_DW: got %h want 000000a5", d_DW); end
    checks++; if (d_WA !== 5'd3) begin fails++; $display("FAIL alu_WA: got %0d want 3", d_WA); end
    checks++; if (d_wE !== 1'b1) begin fails++; $display("FAIL alu_wE: got %b want 1", d_wE); end
    checks++; if (d_stall !== 1'b0) begin fails++; $display("FAIL alu_stall: got %b want 0", d_stall); end
    idle(1);
    checks++; if (d_ov !== 1'b0) begin fails++; $display("FAIL idle_ov: got %b want 0", d_ov); end
    checks++; if (d_wE !== 1'b0) begin fails++; $display("FAIL idle_wE: got %b want 0", d_wE); end
    checks++; if (d_DW !== 32'h0000_00A5) begin fails++; $display("FAIL idle_DW_hold: got %h want 000000a5", d_DW); end
    checks++; if (d_WA !== 5'd3) begin fails++; $display("FAIL idle_WA_hold: got %0d want 3", d_WA); end
  endtask

  task automatic test_store_load;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd9);
    tick();
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL st_ov: got %b want 1", d_ov); end
    checks++; if (d_DW !== 32'h10) begin fails++; $display("FAIL st_DW: got %h want 00000010", d_DW); end
    checks++; if (d_wE !== 1'b0) begin fails++; $display("FAIL st_wE: got %b want 0", d_wE); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd7);
    tick();
    checks++; if (d_stall !== 1'b1) begin fails++; $display("FAIL ld_stall: got %b want 1", d_stall); end
    checks++; if (d_ov !== 1'b0) begin fails++; $display("FAIL ld_ov_early: got %b want 0", d_ov); end
    checks++; if (d_wE !== 1'b0) begin fails++; $display("FAIL ld_wE_early: got %b want 0", d_wE); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL ld_ov: got %b want 1", d_ov); end
    checks++; if (d_DW !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ld_DW: got %h want deadbeef", d_DW); end
    checks++; if (d_WA !== 5'd7) begin fails++; $display("FAIL ld_WA: got %0d want 7", d_WA); end
    checks++; if (d_wE !== 1'b1) begin fails++; $display("FAIL ld_wE: got %b want 1", d_wE); end
    checks++; if (d_stall !== 1'b0) begin fails++; $display("FAIL ld_stall_end: got %b want 0", d_stall); end
    tick();
    checks++; if (d_ov !== 1'b0) begin fails++; $display("FAIL ld_ov_after: got %b want 0", d_ov); end
  endtask

  task automatic test_wrap;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1234_5678, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h000, 32'h0, 5'd5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL wrap_ov: got %b want 1", d_ov); end
    checks++; if (d_DW !== 32'h1234_5678) begin fails++; $display("FAIL wrap_DW: got %h want 12345678", d_DW); end
    checks++; if (d_WA !== 5'd5) begin fails++; $display("FAIL wrap_WA: got %0d want 5", d_WA); end
  endtask

  task automatic test_wait_hold;
    idle(4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'hCAFE_F00D, 5'd0);
    tick();
    checks++; if (q_ov !== 1'b1) begin fails++; $display("FAIL h_st_ov: got %b want 1", q_ov); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd12);
    tick();
    checks++; if (q_stall !== 1'b1) begin fails++; $display("FAIL h_stall0: got %b want 1", q_stall); end
    // Competing store to the same word while stalled must be ignored.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0BAD_0BAD, 5'd1);
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++; if (q_stall !== 1'b1) begin fails++; $display("FAIL h_stall%0d: got %b want 1", e, q_stall); end
      checks++; if (q_ov !== 1'b0) begin fails++; $display("FAIL h_ov%0d: got %b want 0", e, q_ov); end
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (q_ov !== 1'b1) begin fails++; $display("FAIL h_ov3: got %b want 1", q_ov); end
    checks++; if (q_DW !== 32'hCAFE_F00D) begin fails++; $display("FAIL h_DW: got %h want cafef00d", q_DW); end
    checks++; if (q_WA !== 5'd12) begin fails++; $display("FAIL h_WA: got %0d want 12", q_WA); end
    checks++; if (q_wE !== 1'b1) begin fails++; $display("FAIL h_wE: got %b want 1", q_wE); end
    checks++; if (q_stall !== 1'b0) begin fails++; $display("FAIL h_stall3: got %b want 0", q_stall); end
    tick();
    checks++; if (q_ov !== 1'b0) begin fails++; $display("FAIL h_ov4: got %b want 0", q_ov); end
    checks++; if (q_DW !== 32'hCAFE_F00D) begin fails++; $display("FAIL h_DW_hold: got %h want cafef00d", q_DW); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    checks++; if (q_ov !== 1'b1) begin fails++; $display("FAIL h_reld_ov: got %b want 1", q_ov); end
    checks++; if (q_DW !== 32'hCAFE_F00D) begin fails++; $display("FAIL h_reld_DW: got %h want cafef00d", q_DW); end
    checks++; if (q_WA !== 5'd2) begin fails++; $display("FAIL h_reld_WA: got %0d want 2", q_WA); end
  endtask

  task automatic test_reset_mid_wait;
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd4);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd7);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (d_stall !== 1'b1) begin fails++; $display("FAIL rw_stall_pre: got %b want 1", d_stall); end
    checks++; if (d_DW !== 32'h77) begin fails++; $display("FAIL rw_DW_pre: got %h want 00000077", d_DW); end
    #2 rst = 1'b1;
    #1;
    checks++; if (d_stall !== 1'b0) begin fails++; $display("FAIL rw_stall: got %b want 0", d_stall); end
    checks++; if (d_DW !== 32'h0) begin fails++; $display("FAIL rw_DW: got %h want 0", d_DW); end
    checks++; if (d_WA !== 5'h0) begin fails++; $display("FAIL rw_WA: got %h want 0", d_WA); end
    checks++; if (d_ov !== 1'b0) begin fails++; $display("FAIL rw_ov: got %b want 0", d_ov); end
    #2 rst = 1'b0;
    tick();
    checks++; if (d_ov !== 1'b0) begin fails++; $display("FAIL rw_no_result: got %b want 0", d_ov); end
    checks++; if (d_wE !== 1'b0) begin fails++; $display("FAIL rw_no_wE: got %b want 0", d_wE); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_001F, 32'h0, 5'd30);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL rw_alu_ov: got %b want 1", d_ov); end
    checks++; if (d_DW !== 32'h1F) begin fails++; $display("FAIL rw_alu_DW: got %h want 0000001f", d_DW); end
    checks++; if (d_WA !== 5'd30) begin fails++; $display("FAIL rw_alu_WA: got %0d want 30", d_WA); end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align;
    idle(4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1111_2222, 5'd0);
    tick();
    checks++; if (d_mis !== 1'b0) begin fails++; $display("FAIL al_st_ok: got %b want 0", d_mis); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h12, 32'hFFFF_FFFF, 5'd0);
    tick();
    checks++; if (d_mis !== 1'b1) begin fails++; $display("FAIL al_st_mis: got %b want 1", d_mis); end
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL al_st_ov: got %b want 1", d_ov); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checks++; if (d_DW !== 32'h1111_2222) begin fails++; $display("FAIL al_ram_kept: got %h want 11112222", d_DW); end
    checks++; if (d_mis !== 1'b0) begin fails++; $display("FAIL al_ld_ok: got %b want 0", d_mis); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd6);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    checks++; if (d_ov !== 1'b1) begin fails++; $display("FAIL al_ld_ov: got %b want 1", d_ov); end
    checks++; if (d_mis !== 1'b1) begin fails++; $display("FAIL al_ld_mis: got %b want 1", d_mis); end
    checks++; if (d_DW !== 32'h0) begin fails++; $display("FAIL al_ld_DW: got %h want 0", d_DW); end
    checks++; if (d_wE !== 1'b0) begin fails++; $display("FAIL al_ld_wE: got %b want 0", d_wE); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_wrap();
    test_wait_hold();
    test_reset_mid_wait();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
